// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// master = producer of instructions and consumer of immediates; slave = the generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 64
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_fmt,
        input  out_illegal
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_fmt,
        output out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage RISC-V immediate generator (I/S/B/J/SHAMT, optional U) with valid/ready.
// Optional feature macro IMMGEN_UTYPE_EN: when defined, lui/auipc decode as U-type; else they flag illegal.
module imm_gen_pipe #(
    parameter int unsigned XLEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic            s1_valid;
    logic [31:0]     s1_instr;
    logic            out_valid_q;
    logic [XLEN-1:0] out_imm_q;
    fmt_e            out_fmt_q;
    logic            out_illegal_q;

    logic            s1_adv;
    logic            s2_adv;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    // Flow control: a stage advances when it is empty or its downstream advances.
    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_fmt     = out_fmt_q;
    assign bus.out_illegal = out_illegal_q;

    assign opcode   = s1_instr[6:0];
    assign funct3   = s1_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every immediate is first assembled as a signed 32-bit value, then widened to XLEN.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b1;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_imm     = sext32({{20{s1_instr[31]}}, s1_instr[31:20]});
                dec_fmt     = FMT_I;
                dec_illegal = 1'b0;
            end
            OP_IMM: begin
                dec_illegal = 1'b0;
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    if (XLEN == 64) begin
                        dec_imm = XLEN'(s1_instr[25:20]);
                    end else begin
                        dec_imm = XLEN'(s1_instr[24:20]);
                    end
                end else begin
                    dec_imm = sext32({{20{s1_instr[31]}}, s1_instr[31:20]});
                    dec_fmt = FMT_I;
                end
            end
            OP_IMM32: begin
                // Word-sized op-imm only exists on RV64; shamt is always 5 bits here.
                if (XLEN == 64) begin
                    dec_illegal = 1'b0;
                    if (is_shift) begin
                        dec_imm = XLEN'(s1_instr[24:20]);
                        dec_fmt = FMT_SHAMT;
                    end else begin
                        dec_imm = sext32({{20{s1_instr[31]}}, s1_instr[31:20]});
                        dec_fmt = FMT_I;
                    end
                end
            end
            OP_STORE: begin
                dec_imm     = sext32({{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]});
                dec_fmt     = FMT_S;
                dec_illegal = 1'b0;
            end
            OP_BRANCH: begin
                dec_imm     = sext32({{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                                      s1_instr[30:25], s1_instr[11:8], 1'b0});
                dec_fmt     = FMT_B;
                dec_illegal = 1'b0;
            end
            OP_JAL: begin
                dec_imm     = sext32({{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                                      s1_instr[20], s1_instr[30:21], 1'b0});
                dec_fmt     = FMT_J;
                dec_illegal = 1'b0;
            end
`ifdef IMMGEN_UTYPE_EN
            OP_LUI, OP_AUIPC: begin
                dec_imm     = sext32({s1_instr[31:12], 12'b0});
                dec_fmt     = FMT_U;
                dec_illegal = 1'b0;
            end
`else
            OP_LUI, OP_AUIPC: begin
                dec_imm     = '0;
                dec_fmt     = FMT_NONE;
                dec_illegal = 1'b1;
            end
`endif
            default: begin
                dec_imm     = '0;
                dec_fmt     = FMT_NONE;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Stage 1: instruction register; flush wins over any accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_instr <= bus.in_instr;
            end
        end
    end

    // Stage 2: decoded result; data holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_imm_q     <= '0;
            out_fmt_q     <= FMT_NONE;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_imm_q     <= dec_imm;
                out_fmt_q     <= dec_fmt;
                out_illegal_q <= dec_illegal;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe at XLEN 64 and 32.
// Expected lui/auipc results follow IMMGEN_UTYPE_EN as defined for the build.
module tb_imm_gen_pipe;
    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

    imm_gen_pipe_if #(.XLEN(64)) bus64 ();
    imm_gen_pipe_if #(.XLEN(32)) bus32 ();

    imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));
    imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef IMMGEN_UTYPE_EN
    localparam logic [63:0] LUI64   = 64'h0000_0000_1234_5000;
    localparam logic [63:0] AUIPC64 = 64'hFFFF_FFFF_8000_0000;
    localparam logic [31:0] LUI32   = 32'h1234_5000;
    localparam logic [2:0]  UFMT    = 3'd4;
    localparam logic        UILL    = 1'b0;
`else
    localparam logic [63:0] LUI64   = 64'h0;
    localparam logic [63:0] AUIPC64 = 64'h0;
    localparam logic [31:0] LUI32   = 32'h0;
    localparam logic [2:0]  UFMT    = 3'd0;
    localparam logic        UILL    = 1'b1;
`endif

    localparam int N64 = 13;
    logic [31:0] d64_instr [N64] = '{32'hFFF00093, 32'hFE000EE3, 32'h43F0D093, 32'h123450B7,
                                     32'h80000097, 32'hFE20AC23, 32'h0080006F, 32'h7FF12083,
                                     32'h80008067, 32'h02109093, 32'hFFF0809B, 32'h41F0D09B,
                                     32'h002081B3};
    logic [63:0] d64_imm [N64] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'h3F, LUI64,
                                   AUIPC64, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8, 64'h7FF,
                                   64'hFFFF_FFFF_FFFF_F800, 64'h21, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1F,
                                   64'h0};
    logic [2:0] d64_fmt [N64] = '{3'd1, 3'd3, 3'd6, UFMT, UFMT, 3'd2, 3'd5, 3'd1, 3'd1, 3'd6,
                                  3'd1, 3'd6, 3'd0};
    logic d64_ill [N64] = '{1'b0, 1'b0, 1'b0, UILL, UILL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1};

    localparam int N32 = 6;
    logic [31:0] d32_instr [N32] = '{32'hFFF00093, 32'h43F0D093, 32'hFFF0809B, 32'h123450B7,
                                     32'hFE000EE3, 32'h0080006F};
    logic [31:0] d32_imm [N32] = '{32'hFFFF_FFFF, 32'h1F, 32'h0, LUI32, 32'hFFFF_FFFC, 32'h8};
    logic [2:0] d32_fmt [N32] = '{3'd1, 3'd6, 3'd0, UFMT, 3'd3, 3'd5};
    logic d32_ill [N32] = '{1'b0, 1'b0, 1'b1, UILL, 1'b0, 1'b0};

    // Present one instruction for a single cycle; returns when its result should be in stage 2.
    task automatic push64(input logic [31:0] instr);
        bus64.in_instr  = instr;
        bus64.in_valid  = 1'b1;
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic push32(input logic [31:0] instr);
        bus32.in_instr  = instr;
        bus32.in_valid  = 1'b1;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.out_imm !== 64'h0 || bus64.out_fmt !== 3'd0
            || bus64.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_out64: valid=%b imm=%h fmt=%0d ill=%b, expected all zero",
                     bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_illegal);
        end
        checks++;
        if (bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus64.in_ready);
        end
        checks++;
        if (bus32.out_valid !== 1'b0 || bus32.out_imm !== 32'h0) begin
            errors++;
            $display("FAIL reset_out32: valid=%b imm=%h, expected 0/0", bus32.out_valid, bus32.out_imm);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: out_valid=%b in_ready=%b expected 0/1",
                     bus64.out_valid, bus64.in_ready);
        end
    endtask

    task automatic test_decode64();
        for (int i = 0; i < N64; i++) begin
            push64(d64_instr[i]);
            checks++;
            if (bus64.out_valid !== 1'b1 || bus64.out_imm !== d64_imm[i]
                || bus64.out_fmt !== d64_fmt[i] || bus64.out_illegal !== d64_ill[i]) begin
                errors++;
                $display("FAIL decode64[%0d] instr=%h: valid=%b imm=%h fmt=%0d ill=%b, expected 1 %h %0d %b",
                         i, d64_instr[i], bus64.out_valid, bus64.out_imm, bus64.out_fmt,
                         bus64.out_illegal, d64_imm[i], d64_fmt[i], d64_ill[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_decode32();
        for (int i = 0; i < N32; i++) begin
            push32(d32_instr[i]);
            checks++;
            if (bus32.out_valid !== 1'b1 || bus32.out_imm !== d32_imm[i]
                || bus32.out_fmt !== d32_fmt[i] || bus32.out_illegal !== d32_ill[i]) begin
                errors++;
                $display("FAIL decode32[%0d] instr=%h: valid=%b imm=%h fmt=%0d ill=%b, expected 1 %h %0d %b",
                         i, d32_instr[i], bus32.out_valid, bus32.out_imm, bus32.out_fmt,
                         bus32.out_illegal, d32_imm[i], d32_fmt[i], d32_ill[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    // Four addi (imm 1..4) streamed back to back; consumer stalls in cycles 3..5.
    task automatic test_back_to_back();
        logic [31:0] s_instr [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
        logic [9:0]  exp_rdy = 10'b1111000111;
        logic [9:0]  exp_ov  = 10'b0111111100;
        int          exp_imm [10] = '{0, 0, 1, 2, 2, 2, 2, 3, 4, 0};
        int          sent = 0;
        int          got  = 0;
        for (int c = 0; c < 10; c++) begin
            bus64.out_ready = !(c >= 3 && c <= 5);
            bus64.in_valid  = (sent < 4);
            bus64.in_instr  = (sent < 4) ? s_instr[sent] : 32'h0;
            #1;
            checks++;
            if (bus64.in_ready !== exp_rdy[c]) begin
                errors++;
                $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", c, bus64.in_ready, exp_rdy[c]);
            end
            checks++;
            if (bus64.out_valid !== exp_ov[c]) begin
                errors++;
                $display("FAIL b2b_out_valid cycle %0d: got %b expected %b", c, bus64.out_valid, exp_ov[c]);
            end
            if (exp_ov[c]) begin
                checks++;
                if (bus64.out_imm !== 64'(exp_imm[c])) begin
                    errors++;
                    $display("FAIL b2b_out_imm cycle %0d: got %h expected %h", c, bus64.out_imm, 64'(exp_imm[c]));
                end
            end
            if (bus64.out_valid === 1'b1 && bus64.out_ready) got++;
            if (bus64.in_valid && bus64.in_ready === 1'b1) sent++;
            @(posedge clk); #1;
        end
        bus64.in_valid = 1'b0;
        checks++;
        if (got != 4 || sent != 4) begin
            errors++;
            $display("FAIL b2b_count: consumed %0d accepted %0d, expected 4 and 4", got, sent);
        end
    endtask

    task automatic test_flush();
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = 32'h00500093;
        @(posedge clk); #1;
        bus64.in_instr = 32'h00600093;
        @(posedge clk); #1;
        checks++;
        if (bus64.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_full_ready: got %b expected 0", bus64.in_ready);
        end
        flush          = 1'b1;
        bus64.in_instr = 32'h00700093;
        @(posedge clk); #1;
        flush          = 1'b0;
        bus64.in_valid = 1'b0;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: out_valid=%b in_ready=%b expected 0/1",
                     bus64.out_valid, bus64.in_ready);
        end
        bus64.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus64.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost[%0d]: out_valid=%b imm=%h expected no output",
                         i, bus64.out_valid, bus64.out_imm);
            end
        end
        // Flush on an idle pipe with a same-cycle accept: that accept is dropped too.
        flush          = 1'b1;
        bus64.in_valid = 1'b1;
        bus64.in_instr = 32'h00900093;
        @(posedge clk); #1;
        flush          = 1'b0;
        bus64.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus64.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_accept_drop[%0d]: out_valid=%b expected 0", i, bus64.out_valid);
            end
        end
        push64(32'h00800093);
        checks++;
        if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'h8) begin
            errors++;
            $display("FAIL flush_recover: valid=%b imm=%h expected 1/%h", bus64.out_valid, bus64.out_imm, 64'h8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bus64.out_ready = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.in_instr  = 32'h00100093;
        @(posedge clk); #1;
        bus64.in_instr = 32'h00200093;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        checks++;
        if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'h1) begin
            errors++;
            $display("FAIL areset_pre: valid=%b imm=%h expected 1/%h", bus64.out_valid, bus64.out_imm, 64'h1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus64.out_valid !== 1'b0 || bus64.out_imm !== 64'h0 || bus64.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_async: valid=%b imm=%h in_ready=%b expected 0/0/1",
                     bus64.out_valid, bus64.out_imm, bus64.in_ready);
        end
        @(posedge clk); #1;
        rst_n           = 1'b1;
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus64.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_drop: out_valid=%b imm=%h expected in-flight entry dropped",
                     bus64.out_valid, bus64.out_imm);
        end
        push64(32'h00300093);
        checks++;
        if (bus64.out_valid !== 1'b1 || bus64.out_imm !== 64'h3) begin
            errors++;
            $display("FAIL areset_first: valid=%b imm=%h expected 1/%h", bus64.out_valid, bus64.out_imm, 64'h3);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst_n           = 1'b1;
        flush           = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_instr  = 32'h0;
        bus64.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in_instr  = 32'h0;
        bus32.out_ready = 1'b1;
        test_reset();
        test_decode64();
        test_decode32();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised RISC-V immediate generator for the multicycle datapath. It decodes every base-ISA immediate format (I, S, B, U, J, shift-amount) at XLEN 32 or 64, sign-extends correctly per format, and flags opcodes with no immediate. Two registered stages with valid/ready handshakes let it sit between the instruction register and the ALU-operand mux, with stall and flush support.

## Interface
- XLEN, 64, immediate width; legal values 32 or 64.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; empties both stages.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage 1 can accept this cycle (combinational).
- in_instr  in  32  instruction word.
- out_valid  out  1  stage 2 holds a result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_imm  out  XLEN  immediate.
- out_fmt  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_illegal  out  1  opcode carries no supported immediate.

## Operation
- Stage 1 (S1): registers in_instr and a valid bit on accept (in_valid && in_ready).
- Stage 2 (S2): registers the decoded out_imm/out_fmt/out_illegal and out_valid from S1.
- Decode by opcode inst[6:0]; sext = replicate inst[31] up to XLEN:
  - 0000011 load, 1100111 jalr, 0010011 op-imm (funct3 ≠ 001/101): I, sext(inst[31:20]).
  - 0010011 funct3 001/101: SHAMT, zero-extended inst[25:20] (XLEN=64) or inst[24:20] (XLEN=32); funct7 bits not included.
  - 0011011 op-imm-32 (XLEN=64 only): I or SHAMT as above, shamt inst[24:20]; with XLEN=32, treated as illegal.
  - 0100011 store: S, sext({inst[31:25],inst[11:7]}).
  - 1100011 branch: B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 1101111 jal: J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 0110111 lui, 0010111 auipc: per Configuration.
  - Any other opcode: out_imm 0, out_fmt 0, out_illegal 1.
- Jalr is sign-extended like every other I-type immediate.

## Timing
- Reset (rst_n low, asynchronous): S1/S2 valid 0, S1 instruction 0, out_valid 0, out_imm 0, out_fmt 0, out_illegal 0; in_ready is 1 immediately after reset.
- s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
- Latency: 2 cycles from accept to out_valid; throughput 1 per cycle while out_ready is held high.
- Back-pressure: while out_valid && !out_ready, out_imm/fmt/illegal hold stable; S1 holds if full; in_ready drops only when both stages are full.
- S2 data registers load only on s2_adv with s1_valid; valid bits update every cycle.
- flush: next edge clears both valid bits; a same-cycle input accept is discarded; data registers need not clear. flush has priority over all advances.
- Reset asserted mid-transfer drops all in-flight entries; no output is produced for them.

## Configuration
- IMMGEN_UTYPE_EN defined: lui/auipc decode as U, out_imm = sext({inst[31:12],12'b0}), out_illegal 0.
- Undefined: lui/auipc decode as none: out_imm 0, out_fmt 0, out_illegal 1.

## Test plan
- XLEN=64, 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> 2 cycles later out_imm 0xFFFFFFFFFFFFFFFF, fmt 1, illegal 0.
- XLEN=64, 0xFE000EE3 (beq -4) -> out_imm 0xFFFFFFFFFFFFFFFC, fmt 3; 0x43F0D093 (srai x1,x1,63) -> out_imm 0x3F, fmt 6.
- 0x123450B7 (lui): with IMMGEN_UTYPE_EN -> 0x0000000012345000, fmt 4; without it -> 0, fmt 0, illegal 1; XLEN=32 with the macro defined -> 0x12345000.
- Back-to-back stream of 4 instructions with out_ready low for cycles 3-5 -> in_ready low only while both stages are full; no result lost or duplicated; out_imm stable throughout the stall.
- flush asserted while both stages are full and in_valid is high -> next cycle out_valid 0, in_ready 1; the flushed instructions never appear on the output.
- rst_n pulled low asynchronously mid-stream -> out_valid and out_imm go to 0 without waiting for a clock edge; the first instruction accepted after reset returns out_valid 2 cycles later.
